// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - requester, ALU, response and condition-code signals of the shared-ALU arbiter
interface alu_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 64
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_fn;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_setcc;
  logic [1:0]        alu_sel;
  logic [W-1:0]      alu_x;
  logic [W-1:0]      alu_y;
  logic [W-1:0]      alu_z;
  logic              alu_ovf;
  logic              resp_valid;
  logic              resp_ready;
  logic [1:0]        resp_id;
  logic [W-1:0]      resp_data;
  logic              cc_zf;
  logic              cc_sf;
  logic              cc_of;
  logic              busy;

  modport slave (
    input  req_valid, req_fn, req_a, req_b, req_setcc, alu_z, alu_ovf, resp_ready,
    output req_ready, alu_sel, alu_x, alu_y, resp_valid, resp_id, resp_data,
           cc_zf, cc_sf, cc_of, busy
  );

  modport master (
    output req_valid, req_fn, req_a, req_b, req_setcc, alu_z, alu_ovf, resp_ready,
    input  req_ready, alu_sel, alu_x, alu_y, resp_valid, resp_id, resp_data,
           cc_zf, cc_sf, cc_of, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU among NREQ requesters, owns the ZF/SF/OF register
// ALU_ARB_PRIO0_EN gives requester 0 strict priority over the round-robin group 1..NREQ-1.
module alu_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 64
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  alu_share_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [1:0]      fn_q, fn_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            setcc_q, setcc_d;
  logic [W-1:0]    resp_data_q, resp_data_d;
  logic            zf_q, zf_d;
  logic            sf_q, sf_d;
  logic            of_q, of_d;
  logic [NREQ-1:0] req_ready;
  logic            grant_found;
  logic [1:0]      grant_idx;

  function automatic logic [1:0] wrap_idx(input logic [1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return 2'(s);
  endfunction

  function automatic logic [1:0] next_ptr(input logic [1:0] g);
    if (int'(g) == NREQ - 1) return 2'd0;
    return g + 2'd1;
  endfunction

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 2'd0;
`ifdef ALU_ARB_PRIO0_EN
    if (bus.req_valid[0]) begin
      grant_found = 1'b1;
      grant_idx   = 2'd0;
    end
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found && bus.req_valid[wrap_idx(rr_ptr_q, k)]
`ifdef ALU_ARB_PRIO0_EN
          && (wrap_idx(rr_ptr_q, k) != 2'd0)
`endif
         ) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    fn_d        = fn_q;
    a_d         = a_q;
    b_d         = b_q;
    setcc_d     = setcc_q;
    resp_data_d = resp_data_q;
    zf_d        = zf_q;
    sf_d        = sf_q;
    of_d        = of_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          gnt_d   = grant_idx;
          fn_d    = bus.req_fn[2*grant_idx +: 2];
          a_d     = bus.req_a[W*grant_idx +: W];
          b_d     = bus.req_b[W*grant_idx +: W];
          setcc_d = bus.req_setcc[grant_idx];
          state_d = EXEC;
        end
      end
      EXEC: begin
        resp_data_d = bus.alu_z;
        if (setcc_q) begin
          zf_d = (bus.alu_z == '0);
          sf_d = bus.alu_z[W-1];
          // Overflow is only meaningful for add/sub; logic ops clear it.
          of_d = fn_q[1] ? 1'b0 : bus.alu_ovf;
        end
        state_d = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
`ifdef ALU_ARB_PRIO0_EN
          if (gnt_q != 2'd0) rr_ptr_d = next_ptr(gnt_q);
`else
          rr_ptr_d = next_ptr(gnt_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 2'd0;
      gnt_q       <= 2'd0;
      fn_q        <= 2'd0;
      a_q         <= '0;
      b_q         <= '0;
      setcc_q     <= 1'b0;
      resp_data_q <= '0;
      zf_q        <= 1'b1;
      sf_q        <= 1'b0;
      of_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      fn_q        <= fn_d;
      a_q         <= a_d;
      b_q         <= b_d;
      setcc_q     <= setcc_d;
      resp_data_q <= resp_data_d;
      zf_q        <= zf_d;
      sf_q        <= sf_d;
      of_q        <= of_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.alu_sel    = fn_q;
  assign bus.alu_x      = a_q;
  assign bus.alu_y      = b_q;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_id    = gnt_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.cc_zf      = zf_q;
  assign bus.cc_sf      = sf_q;
  assign bus.cc_of      = of_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed vector bench for alu_share_arbiter with a behavioural ALU
`timescale 1ns/100ps
module tb_alu_share_arbiter;

  typedef struct {
    int          id;
    logic [1:0]  fn;
    logic [63:0] a;
    logic [63:0] b;
    logic        setcc;
    logic [63:0] exp_data;
    logic [2:0]  exp_cc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [63:0] alu_z_m;
  logic        alu_ovf_m;

  alu_share_arbiter_if #(.NREQ(4), .W(64)) bus ();

  alu_share_arbiter #(.NREQ(4), .W(64)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Logic ops report x[63] as overflow so the arbiter must mask it.
  always_comb begin
    alu_z_m   = '0;
    alu_ovf_m = 1'b0;
    case (bus.alu_sel)
      2'b00: begin
        alu_z_m   = bus.alu_x + bus.alu_y;
        alu_ovf_m = (bus.alu_x[63] == bus.alu_y[63]) && (alu_z_m[63] != bus.alu_x[63]);
      end
      2'b01: begin
        alu_z_m   = bus.alu_x - bus.alu_y;
        alu_ovf_m = (bus.alu_x[63] != bus.alu_y[63]) && (alu_z_m[63] != bus.alu_x[63]);
      end
      2'b10: begin
        alu_z_m   = bus.alu_x & bus.alu_y;
        alu_ovf_m = bus.alu_x[63];
      end
      default: begin
        alu_z_m   = bus.alu_x ^ bus.alu_y;
        alu_ovf_m = bus.alu_x[63];
      end
    endcase
  end
  assign bus.alu_z   = alu_z_m;
  assign bus.alu_ovf = alu_ovf_m;

  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      if ((bus.busy && bus.req_ready != 4'b0) || !$onehot0(bus.req_ready)) begin
        fails++;
        $display("FAIL ready_onehot_idle: got req_ready=%b busy=%b, expected one-hot only in IDLE",
                 bus.req_ready, bus.busy);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [1:0] fn, input logic [63:0] a,
                         input logic [63:0] b, input logic setcc);
    bus.req_fn[2*id +: 2]  = fn;
    bus.req_a[64*id +: 64] = a;
    bus.req_b[64*id +: 64] = b;
    bus.req_setcc[id]      = setcc;
  endtask

  task automatic wait_grant(output logic [3:0] rdy);
    rdy = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.req_ready != 4'b0) begin
        rdy = bus.req_ready;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL grant_timeout: got no req_ready, expected a grant within 20 cycles");
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      n++;
      if (bus.resp_valid) return;
    end
    n = -1;
    tests++;
    fails++;
    $display("FAIL resp_timeout: got no resp_valid, expected a response within 30 cycles");
  endtask

  vec_t        vecs[8];
  int          exp_rr[5];
  int          exp_pr[4];
  logic [3:0]  rdy;
  logic [3:0]  onehot;
  int          n;
  int          seen;

  initial begin
    vecs[0] = '{0, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 64'h8000_0000_0000_0000, 3'b011};
    vecs[1] = '{1, 2'b01, 64'h1234, 64'h1234, 1'b1, 64'h0, 3'b100};
    vecs[2] = '{2, 2'b11, 64'h5, 64'h3, 1'b0, 64'h6, 3'b100};
    vecs[3] = '{3, 2'b10, 64'hFF00FF, 64'h0F0F0F, 1'b1, 64'h0F000F, 3'b000};
    vecs[4] = '{0, 2'b01, 64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010};
    vecs[5] = '{1, 2'b01, 64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 3'b001};
    vecs[6] = '{3, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 64'h0, 3'b100};
    vecs[7] = '{2, 2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                64'h8000_0000_0000_0000, 3'b010};
`ifdef ALU_ARB_PRIO0_EN
    exp_rr = '{0, 0, 0, 0, 0};
    exp_pr = '{0, 0, 0, 3};
`else
    exp_rr = '{0, 1, 2, 3, 0};
    exp_pr = '{3, 0, 3, 3};
`endif

    bus.req_valid  = '0;
    bus.req_fn     = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_setcc  = '0;
    bus.resp_ready = 1'b1;

    #12;
    check("rst_resp_valid", {63'b0, bus.resp_valid}, 64'd0);
    check("rst_busy", {63'b0, bus.busy}, 64'd0);
    check("rst_resp_data", bus.resp_data, 64'd0);
    check("rst_resp_id", {62'b0, bus.resp_id}, 64'd0);
    check("rst_cc", {61'b0, bus.cc_zf, bus.cc_sf, bus.cc_of}, 64'b100);
    check("rst_alu", {bus.alu_x | bus.alu_y}, 64'd0);
    check("rst_alu_sel", {62'b0, bus.alu_sel}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      set_req(vecs[i].id, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].setcc);
      onehot = 4'b0001 << vecs[i].id;
      bus.req_valid = onehot;
      wait_grant(rdy);
      check($sformatf("v%0d_ready", i), {60'b0, rdy}, {60'b0, onehot});
      @(posedge clk); #1;
      bus.req_valid = '0;
      wait_resp(n);
      check($sformatf("v%0d_latency", i), 64'(n), 64'd2);
      check($sformatf("v%0d_data", i), bus.resp_data, vecs[i].exp_data);
      check($sformatf("v%0d_id", i), {62'b0, bus.resp_id}, 64'(vecs[i].id));
      check($sformatf("v%0d_cc", i), {61'b0, bus.cc_zf, bus.cc_sf, bus.cc_of}, {61'b0, vecs[i].exp_cc});
    end

    // Asynchronous reset while requester 2 is in EXEC.
    @(posedge clk); #1;
    set_req(2, 2'b00, 64'h10, 64'h20, 1'b1);
    bus.req_valid = 4'b0100;
    wait_grant(rdy);
    check("rstx_ready", {60'b0, rdy}, 64'b0100);
    @(posedge clk); #1;
    bus.req_valid = '0;
    check("rstx_busy_before", {63'b0, bus.busy}, 64'd1);
    #2;
    rst_n = 1'b0;
    #0.5;
    check("rstx_resp_valid", {63'b0, bus.resp_valid}, 64'd0);
    check("rstx_busy", {63'b0, bus.busy}, 64'd0);
    check("rstx_cc", {61'b0, bus.cc_zf, bus.cc_sf, bus.cc_of}, 64'b100);
    #0.5;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.resp_valid) seen++;
    end
    check("rstx_no_resp", 64'(seen), 64'd0);

    // All four requesting continuously.
    @(posedge clk); #1;
    for (int r = 0; r < 4; r++) set_req(r, 2'b00, 64'h100 + 64'(r), 64'h0, 1'b0);
    bus.req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant(rdy);
      onehot = 4'b0001 << exp_rr[g];
      check($sformatf("rr%0d_ready", g), {60'b0, rdy}, {60'b0, onehot});
      wait_resp(n);
      check($sformatf("rr%0d_latency", g), 64'(n), 64'd2);
      check($sformatf("rr%0d_id", g), {62'b0, bus.resp_id}, 64'(exp_rr[g]));
      check($sformatf("rr%0d_data", g), bus.resp_data, 64'h100 + 64'(exp_rr[g]));
    end
    @(posedge clk); #1;
    bus.req_valid = '0;

    // Backpressure with another requester waiting.
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    set_req(1, 2'b01, 64'd10, 64'd3, 1'b0);
    set_req(0, 2'b00, 64'h55, 64'h11, 1'b0);
    bus.req_valid = 4'b0010;
    wait_grant(rdy);
    check("bp_ready", {60'b0, rdy}, 64'b0010);
    @(posedge clk); #1;
    bus.req_valid = 4'b0001;
    wait_resp(n);
    check("bp_latency", 64'(n), 64'd2);
    check("bp_id", {62'b0, bus.resp_id}, 64'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d_valid", c), {63'b0, bus.resp_valid}, 64'd1);
      check($sformatf("bp%0d_data", c), bus.resp_data, 64'd7);
      check($sformatf("bp%0d_ready", c), {60'b0, bus.req_ready}, 64'd0);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", {63'b0, bus.resp_valid}, 64'd1);
    @(negedge clk);
    check("bp_idle_busy", {63'b0, bus.busy}, 64'd0);
    check("bp_idle_grant", {60'b0, bus.req_ready}, 64'b0001);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_resp(n);
    check("bp_next_id", {62'b0, bus.resp_id}, 64'd0);
    check("bp_next_data", bus.resp_data, 64'h66);

    // Requesters 0 and 3 contend; 0 drops before the last grant.
    @(posedge clk); #1;
    set_req(0, 2'b00, 64'hA0, 64'h0, 1'b0);
    set_req(3, 2'b00, 64'hA3, 64'h0, 1'b0);
    bus.req_valid = 4'b1001;
    for (int g = 0; g < 4; g++) begin
      if (g == 3) begin
        @(posedge clk); #1;
        bus.req_valid = 4'b1000;
      end
      wait_grant(rdy);
      onehot = 4'b0001 << exp_pr[g];
      check($sformatf("pr%0d_ready", g), {60'b0, rdy}, {60'b0, onehot});
      wait_resp(n);
      check($sformatf("pr%0d_id", g), {62'b0, bus.resp_id}, 64'(exp_pr[g]));
      check($sformatf("pr%0d_data", g), bus.resp_data, 64'hA0 + 64'(exp_pr[g]));
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 64-bit execute-stage ALU (fn 00 add, 01 sub, 10 and, 11 xor; 64-bit result plus signed-overflow flag) between up to four requesters, e.g. execute stage, address generator and debug port.
- Arbitrates requests, drives the ALU from registered operands, captures the result and returns it with a valid/ready handshake.
- Owns the architectural condition-code register (ZF, SF, OF).

Parameters:
- NREQ, 4, number of requesters; legal values 2..4.
- W, 64, operand and result width.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request
- req_ready  out  NREQ  one-hot accept; combinational, asserted only in IDLE
- req_fn  in  2*NREQ  packed fn codes; requester i occupies bits [2i+1:2i]
- req_a  in  W*NREQ  packed X operands
- req_b  in  W*NREQ  packed Y operands
- req_setcc  in  NREQ  a 1 means the accepted op updates the CC register
- alu_sel  out  2  to ALU select
- alu_x  out  W  to ALU X
- alu_y  out  W  to ALU Y
- alu_z  in  W  ALU result
- alu_ovf  in  1  ALU overflow
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  2  index of the requester that owns the result
- resp_data  out  W  registered result
- cc_zf  out  1  zero flag
- cc_sf  out  1  sign flag
- cc_of  out  1  overflow flag
- busy  out  1  high in EXEC or RESP

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, rr_ptr=0
  - all operand and result registers 0
  - resp_valid=0, resp_id=0, resp_data=0, busy=0
  - cc_zf=1, cc_sf=0, cc_of=0
  - alu_sel/alu_x/alu_y=0
  - An operation in flight is dropped with no response.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - If any req_valid is high, pick the grant g round-robin: first set bit searching from rr_ptr upward, wrapping modulo NREQ.
  - Assert req_ready[g] that cycle only.
  - At the clock edge, latch fn, a, b, setcc and g. Next state is EXEC.
  - If no req_valid is high, stay in IDLE.
- EXEC:
  - alu_sel/alu_x/alu_y are driven from the latched registers; they are held stable for the entire EXEC state.
  - At the edge, resp_data<=alu_z.
  - If setcc is set: cc_zf<=(alu_z==0), cc_sf<=alu_z[W-1], cc_of<=alu_ovf for fn 00/01, otherwise 0.
  - Next state is RESP.
- RESP:
  - resp_valid=1, with resp_id and resp_data stable.
  - On resp_valid&&resp_ready: rr_ptr<=(g+1) mod NREQ, next state IDLE.
  - Otherwise hold; backpressure can last indefinitely with no data change.
- Latency and throughput:
  - Accept in cycle T gives resp_valid in cycle T+2.
  - One op per 3 cycles at best.
  - No new grant is issued while busy; req_ready stays 0 outside IDLE.
- A requester dropping req_valid without being granted is legal; nothing is latched.
- Simultaneous requests: exactly one grant per IDLE cycle; the others wait.
- Fairness: a continuously requesting requester is served within NREQ grants.
- Arithmetic: the ALU wraps modulo 2^W. The controller never alters alu_z; it only samples it.
- CC is unchanged when setcc=0 and unchanged across backpressure.
- req_valid bits at index NREQ and above do not exist. The round-robin pointer never exceeds NREQ-1.

Optional Feature:
- Macro: ALU_ARB_PRIO0_EN.
- Defined: requester 0 has strict priority. Whenever req_valid[0]=1 in IDLE it is granted regardless of rr_ptr. Requesters 1..NREQ-1 are round-robin among themselves. rr_ptr updates only on grants to 1..NREQ-1.
- Undefined: pure round-robin over all requesters, as described in Behaviour.

Test Plan:
- Reset mid-EXEC: with req 2 accepted, pull reset_n low for 1 ns asynchronously. Required: resp_valid=0, busy=0, cc={zf1,sf0,of0} immediately; no response is ever issued for req 2.
- Single add with setcc: req0, fn 00, a=0x7FFF_FFFF_FFFF_FFFF, b=1. Required: resp at T+2 with resp_data=0x8000_0000_0000_0000, resp_id=0, cc_of=1, cc_sf=1, cc_zf=0.
- Sub to zero: req1, fn 01, a=b=0x1234. Required: resp_data=0, zf=1, sf=0, of=0. Then a setcc=0 xor of 5^3 gives resp_data=6 with CC unchanged.
- All four requesting continuously, each with a distinct a: grant order 0,1,2,3,0. Each resp_id matches, and req_ready is one-hot and only in IDLE.
- Backpressure: hold resp_ready=0 for 10 cycles in RESP. Required: resp_valid held, resp_data stable, no req_ready pulses. Release gives IDLE on the next cycle.
- ALU_ARB_PRIO0_EN defined, req0 and req3 continuously valid: req0 is granted every op and req3 is never granted. Drop req0 and req3 is granted next.
